// File: rtl/bin_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state enum, BCD digit width, add-3 threshold, sizing check.
package bin_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DIG_W  = 4;
  localparam int ADJ_TH = 5;

  // True when d decimal digits can hold 2^w-1.
  function automatic bit digits_ok(input int w, input int d);
    longint unsigned p;
    longint unsigned m;
    p = 1;
    m = (64'd1 << w) - 64'd1;
    for (int i = 0; i < d; i++) begin
      if (p <= m) p = p * 10;
    end
    return p > m;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 when the digit is 5 or more.
// Ports: d_i (4-bit BCD digit in), d_o (4-bit corrected digit out).
module bcd_digit_adj
  import bin_bcd_pkg::*;
(
  input  logic [DIG_W-1:0] d_i,
  output logic [DIG_W-1:0] d_o
);

  assign d_o = (d_i >= DIG_W'(ADJ_TH)) ? d_i + DIG_W'(3) : d_i;

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
// Ports: clk, rst_n, in_valid/in_ready/bin, out_valid/out_ready/bcd, busy.
module bin_bcd_seq
  import bin_bcd_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIG_W*D-1:0] bcd,
  output logic             busy
);

  localparam int CW = $clog2(W + 1);
  localparam int AW = DIG_W * D;

  if (W < 4 || W > 32) begin : g_bad_w
    $error("bin_bcd_seq: W must be in 4..32");
  end
  if (!digits_ok(W, D)) begin : g_bad_d
    $error("bin_bcd_seq: D too small for W");
  end

  state_e        state_q, state_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] acc_adj;
  logic [CW-1:0] cnt_q, cnt_d;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (acc_q[DIG_W*g +: DIG_W]),
      .d_o (acc_adj[DIG_W*g +: DIG_W])
    );
  end

  assign in_ready  = (state_q == IDLE) |
                     ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign bcd       = acc_q;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = bin;
          acc_d   = '0;
          cnt_d   = CW'(W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // correct digits first, then shift the whole chain left
        {acc_d, sreg_d} = {acc_adj[AW-2:0], sreg_q, 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            sreg_d  = bin;
            acc_d   = '0;
            cnt_d   = CW'(W);
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Self-checking bench for bin_bcd_seq (W=8/D=3 and W=4/D=2 instances).
// Random and directed operands compared against a decimal-arithmetic model.
module tb_bin_bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv8 = 0, or8 = 0;
  logic [7:0]  bin8 = 0;
  logic        ir8, ov8, busy8;
  logic [11:0] bcd8;

  logic        iv4 = 0, or4 = 0;
  logic [3:0]  bin4 = 0;
  logic        ir4, ov4, busy4;
  logic [7:0]  bcd4;

  bin_bcd_seq #(.W(8), .D(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .bin(bin8),
    .out_valid(ov8), .out_ready(or8), .bcd(bcd8),
    .busy(busy8)
  );

  bin_bcd_seq #(.W(4), .D(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4), .bin(bin4),
    .out_valid(ov4), .out_ready(or4), .bcd(bcd4),
    .busy(busy4)
  );

  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by repeated division.
  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operand, wait for acceptance (bounded), drop in_valid.
  task automatic start8(input logic [7:0] v);
    int n;
    n = 0;
    while (!ir8 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) chk("start_timeout", 0, 1);
    iv8  = 1;
    bin8 = v;
    step();
    acc_cyc = cyc;
    iv8 = 0;
  endtask

  // Wait for out_valid; check latency and value.
  task automatic wait8(input string tag, input int unsigned v);
    int n;
    n = 0;
    while (!ov8 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_lat"}, cyc - acc_cyc + 1, 9);
    chk({tag, "_bcd"}, 32'(bcd8), to_bcd(v) & 32'hfff);
  endtask

  task automatic retire8();
    or8 = 1;
    step();
    or8 = 0;
  endtask

  logic [11:0] held;
  int          c1, c2, n;
  int unsigned rv;

  initial begin
    rst_n = 0;
    step();
    step();
    chk("rst_ir", ir8, 1);
    chk("rst_ov", ov8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_bcd", bcd8, 0);
    chk("rst_ir4", ir4, 1);
    rst_n = 1;
    step();

    // directed corner values
    start8(8'd0);
    chk("busy_shift", busy8, 1);
    chk("ir_shift", ir8, 0);
    wait8("d0", 0);
    chk("busy_done", busy8, 0);
    retire8();
    chk("idle_ov", ov8, 0);
    start8(8'd255); wait8("d255", 255); retire8();
    start8(8'd99);  wait8("d99", 99);   retire8();

    // W=4 sweep
    for (int v = 0; v < 16; v++) begin
      iv4  = 1;
      bin4 = 4'(v);
      step();
      iv4 = 0;
      n = 0;
      while (!ov4 && n < 20) begin
        step();
        n++;
      end
      chk("w4_lat", n + 1, 5);
      chk("w4_bcd", 32'(bcd4), to_bcd(v) & 32'hff);
      or4 = 1;
      step();
      or4 = 0;
    end

    // random operands
    for (int i = 0; i < 20; i++) begin
      rv = $urandom_range(255, 0);
      start8(8'(rv));
      wait8("rnd", rv);
      retire8();
    end

    // back-to-back with out_ready held high
    or8  = 1;
    iv8  = 1;
    bin8 = 8'd200;
    step();
    bin8 = 8'd7;
    n = 0;
    while (!ov8 && n < 40) begin step(); n++; end
    c1 = cyc;
    chk("b2b_bcd1", bcd8, 12'h200);
    chk("b2b_ir1", ir8, 1);
    step();
    n = 0;
    while (!ov8 && n < 40) begin step(); n++; end
    c2 = cyc;
    iv8 = 0;
    chk("b2b_bcd2", bcd8, 12'h007);
    chk("b2b_ir2", ir8, 1);
    chk("b2b_gap", c2 - c1, 9);
    step();
    chk("b2b_idle", ov8, 0);
    or8 = 0;

    // stall with a competing in_valid
    start8(8'd123);
    wait8("stall", 123);
    held = bcd8;
    iv8  = 1;
    bin8 = 8'd45;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_ov", ov8, 1);
      chk("stall_bcd", bcd8, held);
      chk("stall_ir", ir8, 0);
      chk("stall_busy", busy8, 0);
    end
    or8 = 1;
    step();
    acc_cyc = cyc;
    or8 = 0;
    iv8 = 0;
    chk("stall_acc", busy8, 1);
    wait8("stall2", 45);
    retire8();

    // reset on the 4th SHIFT cycle
    start8(8'd77);
    step(); step(); step();
    chk("mid_busy", busy8, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mid_ov", ov8, 0);
    chk("mid_bcd", bcd8, 0);
    chk("mid_ir", ir8, 1);
    chk("mid_busy0", busy8, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ov8) n++;
    end
    chk("mid_noresult", n, 0);
    start8(8'd128); wait8("post_rst", 128); retire8();

    // in_valid pulse during SHIFT
    start8(8'd250);
    step(); step();
    iv8  = 1;
    bin8 = 8'd11;
    chk("pulse_ir", ir8, 0);
    step();
    chk("pulse_ir2", ir8, 0);
    step();
    iv8 = 0;
    wait8("pulse", 250);
    retire8();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
